dram_access_seq: RTL and testbench

Sequencer between the datapath's load/store stage and the byte-wide `DRAM`. It accepts one 32-bit-domain memory request (byte, halfword or word; load or store) through a valid/ready handshake. It splits the request into sequential big-endian byte beats on the DRAM port. It returns a sign- or zero-extended load result, or a misalignment error, as a one-cycle response.

---
 rtl/dram_access_pkg.sv | 32 +++
 rtl/load_extend.sv | 19 +
 rtl/dram_access_seq.sv | 127 ++++++++++++
 tb/tb_dram_access_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_access_pkg.sv
// Shared types and helpers for the byte-serial DRAM access sequencer.
package dram_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        RESP = 2'b10
    } state_t;

    function automatic logic [2:0] beat_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: beat_count = 3'd1;
            SZ_HALF: beat_count = 3'd2;
            default: beat_count = 3'd4;
        endcase
    endfunction

    // Illegal size, or an address not aligned to the access size.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_bad_req = 1'b0;
            SZ_HALF: is_bad_req = addr_lo[0];
            SZ_WORD: is_bad_req = |addr_lo;
            default: is_bad_req = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a right-justified load value to 32 bits.
module load_extend
    import dram_access_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] data
);

    always_comb begin
        case (size)
            SZ_BYTE: data = {{24{is_signed & acc[7]}}, acc[7:0]};
            SZ_HALF: data = {{16{is_signed & acc[15]}}, acc[15:0]};
            default: data = acc;
        endcase
    end

endmodule

// File: rtl/dram_access_seq.sv
// Splits one byte/half/word load or store into big-endian byte beats on a
// byte-wide DRAM port and returns a one-cycle response.
module dram_access_seq
    import dram_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    input  logic [7:0]            mem_rdata
);

    state_t      state, state_nx;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [1:0]  beat;
    logic [31:0] acc;
    logic [23:0] wshift;
    logic [31:0] wdata_al;
    logic [31:0] ext_data;
    logic        req_bad;
    logic        last_beat;

    assign req_bad   = is_bad_req(req_size, req_addr[1:0]);
    assign last_beat = ({1'b0, beat} == (beat_count(size_q) - 3'd1));

    // Left-justify store data so the access's most significant byte sits in [31:24].
    always_comb begin
        case (req_size)
            SZ_BYTE: wdata_al = {req_wdata[7:0], 24'h0};
            SZ_HALF: wdata_al = {req_wdata[15:0], 16'h0};
            default: wdata_al = req_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_bad ? RESP : XFER;
            end
            XFER: if (last_beat) state_nx = RESP;
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                if (!err_q && !write_q) resp_rdata = ext_data;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= SZ_BYTE;
            beat      <= 2'd0;
            acc       <= 32'h0;
            wshift    <= 24'h0;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    write_q  <= req_write;
                    signed_q <= req_signed;
                    size_q   <= req_size;
                    err_q    <= req_bad;
                    beat     <= 2'd0;
                    acc      <= 32'h0;
                    if (!req_bad) begin
                        mem_addr  <= req_addr;
                        mem_wdata <= wdata_al[31:24];
                        wshift    <= wdata_al[23:0];
                        mem_we    <= req_write;
                    end
                end
                XFER: begin
                    if (!write_q) acc <= {acc[23:0], mem_rdata};
                    if (last_beat) begin
                        mem_we <= 1'b0;
                    end else begin
                        beat      <= beat + 2'd1;
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        mem_wdata <= wshift[23:16];
                        wshift    <= {wshift[15:0], 8'h0};
                    end
                end
                default: ;
            endcase
        end
    end

    load_extend u_ext (
        .acc       (acc),
        .size      (size_q),
        .is_signed (signed_q),
        .data      (ext_data)
    );

endmodule

// File: tb/tb_dram_access_seq.sv
// Directed plus random bench for dram_access_seq with a byte-array DRAM model.
module tb_dram_access_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we;

    logic [7:0]  dram    [1024];
    logic [7:0]  ref_mem [1024];
    logic        init_done;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    dram_access_seq #(.ADDR_WIDTH(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = dram[mem_addr];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) dram[i] <= 8'(i * 37 + 5);
        end else if (mem_we && !rst) begin
            dram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from a negedge and follows it to its response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        int n, lat, we_cnt, k;
        logic bad;
        logic [31:0] exp_rd;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bad = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
        exp_rd = 32'h0;
        if (!bad && !w) begin
            for (int i = 0; i < n; i++) exp_rd = (exp_rd << 8) | 32'(ref_mem[10'(a + i)]);
            if (sg && n == 1 && exp_rd >= 32'h80)   exp_rd = exp_rd | 32'hFFFF_FF00;
            if (sg && n == 2 && exp_rd >= 32'h8000) exp_rd = exp_rd | 32'hFFFF_0000;
        end
        if (!bad && w)
            for (int i = 0; i < n; i++) ref_mem[10'(a + i)] = 8'(wd >> (8 * (n - 1 - i)));

        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        chk("ready_before_req", 32'(req_ready), 32'd1);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        lat = 1;
        we_cnt = int'(mem_we);
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
            we_cnt += int'(mem_we);
        end
        chk("resp_latency", 32'(lat), bad ? 32'd1 : 32'(n + 1));
        chk("resp_error",   32'(resp_error), 32'(bad));
        chk("resp_rdata",   resp_rdata, exp_rd);
        chk("we_cycles",    32'(we_cnt), (bad || !w) ? 32'd0 : 32'(n));
        rd = resp_rdata;
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
        chk("ready_after",    32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [9:0]  a;
        int          k;

        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  sz;
        logic [9:0]  a;
        int          k;

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 5);
        init_done = 1'b0;
        rst = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 10'd0; req_wdata = 32'hCAFE_F00D;
        repeat (3) @(negedge clk);
        init_done = 1'b1;
        chk("rst_ready",      32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata",      resp_rdata, 32'h0);
        chk("rst_we",         32'(mem_we), 32'd0);
        chk("rst_addr",       32'(mem_addr), 32'd0);
        chk("rst_wdata",      32'(mem_wdata), 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("dropped_req_dram0", 32'(dram[0]), 32'(ref_mem[0]));

        // Directed cases
        do_req(1'b1, 2'd2, 1'b0, 10'd8, 32'hDEAD_BEEF, rd);
        chk("st_word_b8",  32'(dram[8]),  32'hDE);
        chk("st_word_b9",  32'(dram[9]),  32'hAD);
        chk("st_word_b10", 32'(dram[10]), 32'hBE);
        chk("st_word_b11", 32'(dram[11]), 32'hEF);
        do_req(1'b0, 2'd2, 1'b0, 10'd8, 32'h0, rd);
        chk("ld_word_8", rd, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd0, 1'b1, 10'd9, 32'h0, rd);
        chk("ld_byte_s", rd, 32'hFFFF_FFAD);
        do_req(1'b0, 2'd0, 1'b0, 10'd9, 32'h0, rd);
        chk("ld_byte_u", rd, 32'h0000_00AD);
        do_req(1'b0, 2'd1, 1'b1, 10'd10, 32'h0, rd);
        chk("ld_half_s", rd, 32'hFFFF_BEEF);
        do_req(1'b0, 2'd1, 1'b0, 10'd10, 32'h0, rd);
        chk("ld_half_u", rd, 32'h0000_BEEF);
        do_req(1'b1, 2'd1, 1'b0, 10'd10, 32'h0000_1234, rd);
        chk("st_half_b10", 32'(dram[10]), 32'h12);
        chk("st_half_b11", 32'(dram[11]), 32'h34);
        chk("st_half_b8",  32'(dram[8]),  32'hDE);
        chk("st_half_b9",  32'(dram[9]),  32'hAD);

        do_req(1'b0, 2'd2, 1'b0, 10'd6, 32'h0, rd);
        do_req(1'b1, 2'd1, 1'b0, 10'd3, 32'hFFFF_5A5A, rd);
        do_req(1'b1, 2'd3, 1'b0, 10'd4, 32'h1234_5678, rd);
        for (int i = 2; i < 8; i++) chk("err_dram_intact", 32'(dram[i]), 32'(ref_mem[i]));

        // Store aborted by reset in its third beat
        req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 10'd0; req_wdata = 32'h1122_3344;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready",  32'(req_ready), 32'd1);
        chk("abort_resp",   32'(resp_valid), 32'd0);
        chk("abort_we",     32'(mem_we), 32'd0);
        chk("abort_addr",   32'(mem_addr), 32'd0);
        chk("abort_wdata",  32'(mem_wdata), 32'd0);
        chk("abort_rdata",  resp_rdata, 32'h0);
        chk("abort_err",    32'(resp_error), 32'd0);
        chk("abort_b0", 32'(dram[0]), 32'h11);
        chk("abort_b1", 32'(dram[1]), 32'h22);
        chk("abort_b2", 32'(dram[2]), 32'(ref_mem[2]));
        chk("abort_b3", 32'(dram[3]), 32'(ref_mem[3]));
        ref_mem[0] = 8'h11;
        ref_mem[1] = 8'h22;
        @(negedge clk);
        chk("abort_no_late_resp", 32'(resp_valid), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 10'd0, 32'h0, rd);
        chk("abort_reload", rd, {8'h11, 8'h22, ref_mem[2], ref_mem[3]});

        // Random traffic against the byte-array model
        for (int t = 0; t < 60; t++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = 10'(1016 + $urandom_range(0, 7));
            else                           a = 10'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd2) ? 10'h3FC : (sz == 2'd1) ? 10'h3FE : 10'h3FF);
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd);
            k = $urandom_range(0, 2);
            repeat (k) @(negedge clk);
        end
        for (int i = 0; i < 64; i++)     chk("final_dram_lo", 32'(dram[i]), 32'(ref_mem[i]));
        for (int i = 1016; i < 1024; i++) chk("final_dram_hi", 32'(dram[i]), 32'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
